wuxing_flow_engine: RTL and testbench
=====================================

// Module: wuxing_flow_engine
// PURPOSE
// - Parametrised successor to the five-phase bit-state core: each element carries a
//   multi-bit energy level, not a single bit.
// - A rotating pointer applies generating (sheng) transfers and controlling (ke)
//   suppressions, in hold / sheng / ke / alternating modes, with single-step and load.
// - Drives the same relation-activity bus style (one bit per relation).
// - Adds a wrap pulse and a balance monitor for the simulator front end.
// PARAMETERS
// N_ELEM     5   number of elements; index 0 is earth
// VAL_W      4   level width; MAXV = 2**VAL_W-1
// SHENG_S    1   generating offset (src i -> dst (i+SHENG_S)%N_ELEM)
// KE_S       2   controlling offset (i suppresses (i+KE_S)%N_ELEM)
// INIT_IDX   0   element that is full (MAXV) at reset; pointer start
// THRESH     8   imbalance threshold on max-min
// - Requires gcd(SHENG_S,N_ELEM)==1, so the pointer visits every element.
// - Requires 0<KE_S<N_ELEM and 0<SHENG_S<N_ELEM.
// PORTS
// clk_6Hz    in   1              6 Hz tick clock, single clock domain
// rst_n      in   1              asynchronous, active-low reset
// en         in   1              free-run enable
// step       in   1              single-cycle advance request (used when en=0)
// mode       in   2              00 hold, 01 sheng, 10 ke, 11 alternate
// load       in   1              write load_val into level[load_idx]
// load_idx   in   $clog2(N_ELEM) element to load
// load_val   in   VAL_W          value to load
// level      out  N_ELEM*VAL_W   element levels, element i at [i*VAL_W +: VAL_W]
// ptr        out  $clog2(N_ELEM) active element
// rel_act    out  2*N_ELEM       [N+i] sheng fired from i; [i] ke fired by i
// wrap       out  1              pulse: pointer returned to INIT_IDX
// imbalance  out  1              registered (max(level)-min(level)) >= THRESH
// BEHAVIOUR
// - Reset (async):
//   - level[INIT_IDX]=MAXV, all other levels 0; ptr=INIT_IDX; phase=0.
//   - rel_act=0, wrap=0, imbalance=0.
//   - imbalance may rise on the first clock after reset release.
// - adv = (mode!=00) & (en|step) & ~valid_load, where valid_load = load & (load_idx<N_ELEM).
// - Load:
//   - A valid load writes level[load_idx] on the next edge.
//   - It suppresses adv; ptr, phase and the other levels are held; rel_act=0.
//   - A load with load_idx>=N_ELEM is ignored entirely; adv proceeds normally.
// - Sheng op at p (d=(p+SHENG_S)%N):
//   - Condition: level[p]>0 and level[d]<MAXV.
//   - Action: level[p]-=1, level[d]+=1, rel_act[N+p]=1.
//   - Otherwise no change and the bit stays 0; total energy is always conserved.
// - Ke op at p (t=(p+KE_S)%N):
//   - Condition: level[p]>0 and level[t]>0.
//   - Action: level[t]-=1, rel_act[p]=1; no underflow.
// - Mode 01: sheng op, then ptr<=(ptr+SHENG_S)%N.
// - Mode 10: ke op, then ptr<=(ptr+SHENG_S)%N.
// - Mode 11:
//   - phase 0: sheng op, phase<=1, ptr held.
//   - phase 1: ke op (same ptr), phase<=0, ptr advances.
//   - phase clears to 0 whenever mode!=11.
// - Mode 00: no op, no adv; all levels and ptr held.
// - rel_act and wrap are one-cycle registered pulses, 0 on every non-adv cycle.
//   - All ops evaluate the pre-edge level values.
//   - Latency: the level/ptr update and its pulse appear on the same edge.
// - wrap=1 on an edge where ptr changes and the new ptr==INIT_IDX.
// - imbalance is registered from the pre-edge levels: 1-cycle lag behind level.
// - Simultaneous en and step: a single advance only.
// - Mode change takes effect on the next edge.
// TESTING
// - Reset N=5,W=4 -> level={0,0,0,0,15} (elem4..0), ptr=0, rel_act=0; next cycle imbalance=1.
// - mode=01,en=1, 1 tick -> level0=14, level1=1, rel_act[5]=1, ptr=1; 5 ticks -> ptr=0, wrap=1 on the 5th.
// - level[0]=0, level[2]=3 loaded; mode=10 at ptr=0 -> no change, rel_act=0, ptr=1.
// - Load elem0=5, elem2=3; mode=10 at ptr=0 -> level2=2, rel_act[0]=1.
// - Saturation: load elem1=15; sheng at ptr=0 with level0=14 -> both unchanged, rel_act[5]=0, ptr=1.
// - mode=11 from ptr=0: edge1 sheng with ptr=0; edge2 ke with ptr=0 then ptr=1.
// - load and en together -> only the load happens, ptr held.
// - rst_n low mid-run -> immediate reset values; outputs at reset values before the next edge.

Source files
------------

// File: rtl/wuxing_flow_engine.sv
// wuxing_flow_engine: rotating-pointer five-phase energy engine with sheng/ke transfers
// Ports: clk_6Hz/rst_n clock and async active-low reset; en/step free-run or single advance;
// mode 00 hold, 01 sheng, 10 ke, 11 alternate; load/load_idx/load_val direct level write;
// level packed element levels; ptr active element; rel_act [N+i] sheng from i, [i] ke by i;
// wrap pulse on return to INIT_IDX; imbalance registered max-min >= THRESH.
module wuxing_flow_engine #(
  parameter int N_ELEM   = 5,
  parameter int VAL_W    = 4,
  parameter int SHENG_S  = 1,
  parameter int KE_S     = 2,
  parameter int INIT_IDX = 0,
  parameter int THRESH   = 8
) (
  input  logic                        clk_6Hz,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        step,
  input  logic [1:0]                  mode,
  input  logic                        load,
  input  logic [$clog2(N_ELEM)-1:0]   load_idx,
  input  logic [VAL_W-1:0]            load_val,
  output logic [N_ELEM*VAL_W-1:0]     level,
  output logic [$clog2(N_ELEM)-1:0]   ptr,
  output logic [2*N_ELEM-1:0]         rel_act,
  output logic                        wrap,
  output logic                        imbalance
);
  localparam int IW = $clog2(N_ELEM);
  localparam logic [VAL_W-1:0] MAXV = '1;
  logic [VAL_W-1:0] lv [N_ELEM];
  logic [VAL_W-1:0] lv_n [N_ELEM];
  logic [VAL_W-1:0] mx, mn;
  logic [IW-1:0] d_idx, t_idx, ptr_n;
  logic [2*N_ELEM-1:0] ra_n;
  logic phase, phase_n, valid_load, adv, alt, sheng_ok, ke_ok, move, imb_n;

  function automatic logic [IW-1:0] mod_add(logic [IW-1:0] a, int s);
    int v;
    v = int'(a) + s;
    return IW'(v >= N_ELEM ? v - N_ELEM : v);
  endfunction

  always_ff @(posedge clk_6Hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ELEM; i++) lv[i] <= (i == INIT_IDX) ? MAXV : '0;
      ptr       <= IW'(INIT_IDX);
      phase     <= 1'b0;
      rel_act   <= '0;
      wrap      <= 1'b0;
      imbalance <= 1'b0;
    end else begin
      for (int i = 0; i < N_ELEM; i++) lv[i] <= lv_n[i];
      ptr       <= ptr_n;
      phase     <= phase_n;
      rel_act   <= ra_n;
      wrap      <= move && ptr_n == IW'(INIT_IDX);
      imbalance <= imb_n;
    end
  end

  // alternate mode runs sheng on phase 0 and ke on phase 1 at the same pointer
  always_comb begin
    valid_load = load && int'(load_idx) < N_ELEM;
    adv        = mode != 2'b00 && (en || step) && !valid_load;
    alt        = mode == 2'b11;
    d_idx      = mod_add(ptr, SHENG_S);
    t_idx      = mod_add(ptr, KE_S);
    sheng_ok   = adv && (mode == 2'b01 || (alt && !phase)) && lv[ptr] != '0 && lv[d_idx] != MAXV;
    ke_ok      = adv && (mode == 2'b10 || (alt && phase)) && lv[ptr] != '0 && lv[t_idx] != '0;
    move       = adv && (!alt || phase);
    ptr_n      = move ? d_idx : ptr;
    phase_n    = !alt ? 1'b0 : adv ? !phase : phase;
  end

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      lv_n[i] = lv[i];
      if (valid_load && int'(load_idx) == i) lv_n[i] = load_val;
      if (sheng_ok && int'(ptr) == i) lv_n[i] = lv[i] - 1'b1;
      if (sheng_ok && int'(d_idx) == i) lv_n[i] = lv[i] + 1'b1;
      if (ke_ok && int'(t_idx) == i) lv_n[i] = lv[i] - 1'b1;
    end
    ra_n = sheng_ok ? (2*N_ELEM)'(1) << (N_ELEM + int'(ptr)) :
           ke_ok    ? (2*N_ELEM)'(1) << ptr : '0;
  end

  always_comb begin
    mx = lv[0];
    mn = lv[0];
    for (int i = 1; i < N_ELEM; i++) begin
      mx = lv[i] > mx ? lv[i] : mx;
      mn = lv[i] < mn ? lv[i] : mn;
    end
    imb_n = int'(mx - mn) >= THRESH;
  end

  for (genvar g = 0; g < N_ELEM; g++) begin : g_lv
    assign level[g*VAL_W +: VAL_W] = lv[g];
  end
endmodule

// File: tb/tb_wuxing_flow_engine.sv
// tb_wuxing_flow_engine: directed scoreboard bench for wuxing_flow_engine (N=5, W=4)
module tb_wuxing_flow_engine;
  logic clk_6Hz = 1'b0;
  logic rst_n, en, step, load;
  logic [1:0] mode;
  logic [2:0] load_idx, ptr;
  logic [3:0] load_val;
  logic [19:0] level;
  logic [9:0] rel_act;
  logic wrap, imbalance;

  typedef struct {
    string       tag;
    logic [34:0] v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [19:0] cur_lvl;

  wuxing_flow_engine dut (
    .clk_6Hz(clk_6Hz), .rst_n(rst_n), .en(en), .step(step), .mode(mode),
    .load(load), .load_idx(load_idx), .load_val(load_val),
    .level(level), .ptr(ptr), .rel_act(rel_act), .wrap(wrap), .imbalance(imbalance)
  );

  always #5 clk_6Hz = ~clk_6Hz;

  function automatic logic [19:0] lv(int e0, int e1, int e2, int e3, int e4);
    return {4'(e4), 4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  function automatic logic imb_of(logic [19:0] l);
    int mx, mn, x;
    mx = 0;
    mn = 15;
    for (int i = 0; i < 5; i++) begin
      x = int'(l[i*4 +: 4]);
      if (x > mx) mx = x;
      if (x < mn) mn = x;
    end
    return (mx - mn) >= 8;
  endfunction

  task automatic check_pop();
    exp_t e;
    logic [34:0] obs;
    e = sb.pop_front();
    obs = {level, ptr, rel_act, wrap, imbalance};
    checks++;
    assert (obs === e.v) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed lvl=%h ptr=%0d rel=%h wrap=%b imb=%b, expected lvl=%h ptr=%0d rel=%h wrap=%b imb=%b",
             e.tag, obs[34:15], obs[14:12], obs[11:2], obs[1], obs[0],
             e.v[34:15], e.v[14:12], e.v[11:2], e.v[1], e.v[0]);
    end
  endtask

  // one clock edge; imbalance expectation lags by one cycle (from pre-edge levels)
  task automatic tick(string tag, logic [19:0] el, int ep, logic [9:0] er, logic ew);
    exp_t e;
    e.tag = tag;
    e.v = {el, 3'(ep), er, ew, imb_of(cur_lvl)};
    sb.push_back(e);
    @(posedge clk_6Hz);
    #1;
    check_pop();
    cur_lvl = el;
  endtask

  task automatic do_reset(string tag);
    exp_t e;
    rst_n = 1'b0;
    #1;
    cur_lvl = lv(15, 0, 0, 0, 0);
    e.tag = tag;
    e.v = {cur_lvl, 3'd0, 10'd0, 1'b0, 1'b0};
    sb.push_back(e);
    check_pop();
    @(negedge clk_6Hz);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_in(logic e, logic s, logic [1:0] m, logic l, int li, int lval);
    en = e;
    step = s;
    mode = m;
    load = l;
    load_idx = 3'(li);
    load_val = 4'(lval);
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(0, 0, 2'b00, 0, 0, 0);
    #2;
    do_reset("reset");
    tick("idle_imb", lv(15, 0, 0, 0, 0), 0, 10'h000, 0);
    set_in(1, 0, 2'b01, 0, 0, 0);
    tick("sheng0", lv(14, 1, 0, 0, 0), 1, 10'h020, 0);
    tick("sheng1", lv(14, 0, 1, 0, 0), 2, 10'h040, 0);
    tick("sheng2", lv(14, 0, 0, 1, 0), 3, 10'h080, 0);
    tick("sheng3", lv(14, 0, 0, 0, 1), 4, 10'h100, 0);
    tick("sheng4_wrap", lv(15, 0, 0, 0, 0), 0, 10'h200, 1);
    set_in(0, 1, 2'b01, 0, 0, 0);
    tick("step", lv(14, 1, 0, 0, 0), 1, 10'h020, 0);
    set_in(0, 0, 2'b01, 0, 0, 0);
    tick("no_step", lv(14, 1, 0, 0, 0), 1, 10'h000, 0);
    set_in(1, 1, 2'b01, 0, 0, 0);
    tick("en_and_step", lv(14, 0, 1, 0, 0), 2, 10'h040, 0);
    set_in(1, 0, 2'b01, 0, 0, 0);
    #2;
    do_reset("reset_midrun");
    set_in(0, 0, 2'b00, 1, 0, 0);
    tick("load_e0_0", lv(0, 0, 0, 0, 0), 0, 10'h000, 0);
    set_in(0, 0, 2'b00, 1, 2, 3);
    tick("load_e2_3", lv(0, 0, 3, 0, 0), 0, 10'h000, 0);
    set_in(1, 0, 2'b10, 0, 0, 0);
    tick("ke_src_empty", lv(0, 0, 3, 0, 0), 1, 10'h000, 0);
    tick("ke_p1", lv(0, 0, 3, 0, 0), 2, 10'h000, 0);
    tick("ke_p2", lv(0, 0, 3, 0, 0), 3, 10'h000, 0);
    tick("ke_p3", lv(0, 0, 3, 0, 0), 4, 10'h000, 0);
    tick("ke_p4_wrap", lv(0, 0, 3, 0, 0), 0, 10'h000, 1);
    set_in(1, 0, 2'b10, 1, 0, 5);
    tick("load_with_en", lv(5, 0, 3, 0, 0), 0, 10'h000, 0);
    set_in(1, 0, 2'b10, 0, 0, 0);
    tick("ke_fire", lv(5, 0, 2, 0, 0), 1, 10'h001, 0);
    set_in(1, 0, 2'b10, 1, 5, 9);
    tick("bad_load_idx", lv(5, 0, 2, 0, 0), 2, 10'h000, 0);
    set_in(1, 0, 2'b10, 0, 0, 0);
    tick("ke_p2b", lv(5, 0, 2, 0, 0), 3, 10'h000, 0);
    tick("ke_p3b", lv(5, 0, 2, 0, 0), 4, 10'h000, 0);
    tick("ke_p4b_wrap", lv(5, 0, 2, 0, 0), 0, 10'h000, 1);
    set_in(0, 0, 2'b10, 1, 0, 14);
    tick("load_e0_14", lv(14, 0, 2, 0, 0), 0, 10'h000, 0);
    set_in(0, 0, 2'b10, 1, 1, 15);
    tick("load_e1_15", lv(14, 15, 2, 0, 0), 0, 10'h000, 0);
    set_in(1, 0, 2'b01, 0, 0, 0);
    tick("sheng_sat", lv(14, 15, 2, 0, 0), 1, 10'h000, 0);
    set_in(0, 0, 2'b00, 0, 0, 0);
    #2;
    do_reset("reset_again");
    set_in(0, 0, 2'b00, 1, 2, 4);
    tick("load_e2_4", lv(15, 0, 4, 0, 0), 0, 10'h000, 0);
    set_in(1, 0, 2'b11, 0, 0, 0);
    tick("alt_sheng", lv(14, 1, 4, 0, 0), 0, 10'h020, 0);
    tick("alt_ke", lv(14, 1, 3, 0, 0), 1, 10'h001, 0);
    tick("alt_sheng_p1", lv(14, 0, 4, 0, 0), 1, 10'h040, 0);
    set_in(1, 0, 2'b01, 0, 0, 0);
    tick("mode_sw_sheng", lv(14, 0, 4, 0, 0), 2, 10'h000, 0);
    set_in(1, 0, 2'b11, 0, 0, 0);
    tick("alt_phase_clr", lv(14, 0, 3, 1, 0), 2, 10'h080, 0);
    set_in(1, 0, 2'b00, 0, 0, 0);
    tick("hold", lv(14, 0, 3, 1, 0), 2, 10'h000, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
